// File: rtl/seq_det_rr_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_rr_ctrl
//
// One "111" Mealy detection engine shared among NCH serial channels. Each
// channel keeps its own 2-bit detector context. A round-robin arbiter picks one
// pending channel per cycle. The granted bit is run through the engine, the new
// context is written back, and a completed match is reported with its channel
// id. Each channel also has a saturating match counter.
//
// Build option:
//   SEQ_DET_RR_CTRL_OVERLAP_EN  defined   : after a match the context goes to
//                                           GOT11, so every further 1 matches.
//                               undefined : after a match the context goes to
//                                           GOT1.
//
// Parameters:
//   NCH    number of channels (power of two, 2..16)
//   CH_W   channel-id width, log2(NCH)
//   CNT_W  per-channel match counter width
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   en           global enable; no grants while low
//   in_valid     per-channel bit pending
//   in_bit       per-channel serial bit
//   in_ready     one-hot grant (combinational); transfer = in_valid & in_ready
//   clr_ch       per-channel synchronous clear of context and counter
//   match_valid  registered one-cycle match pulse
//   match_ch     channel of the reported match
//   match_cnt    flattened counters, channel i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module seq_det_rr_ctrl #(
   parameter int NCH   = 4,
   parameter int CH_W  = 2,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH-1:0]       in_bit,
   output logic [NCH-1:0]       in_ready,
   input  logic [NCH-1:0]       clr_ch,
   output logic                 match_valid,
   output logic [CH_W-1:0]      match_ch,
   output logic [NCH*CNT_W-1:0] match_cnt
);

   typedef enum logic [1:0] {
      GN    = 2'b00,
      GOT1  = 2'b01,
      GOT11 = 2'b10
   } state_t;

   // Per-channel context and counters
   state_t               r_ctx [NCH];
   logic [CNT_W-1:0]     r_cnt [NCH];
   logic [CH_W-1:0]      r_rr_ptr;
   logic                 r_match_valid;
   logic [CH_W-1:0]      r_match_ch;

   // Arbiter and engine signals
   logic                 w_xfer;
   logic [CH_W-1:0]      w_gnt;
   logic [CH_W-1:0]      w_idx;
   logic [NCH-1:0]       w_ready;
   state_t               w_cur;
   state_t               w_nxt;
   logic                 w_x;
   logic                 w_match;
   logic                 w_take_match;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // -------------------------------------------------------------------------
   // Round-robin arbiter: first pending channel at or above r_rr_ptr, wrapping.
   // NCH is a power of two, so the CH_W-bit add wraps modulo NCH for free.
   // The grant never looks at in_bit.
   // -------------------------------------------------------------------------
   always_comb begin
      w_xfer  = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      w_ready = '0;
      if (en) begin
         for (int k = 0; k < NCH; k++) begin
            w_idx = r_rr_ptr + CH_W'(k);
            if (!w_xfer && in_valid[w_idx]) begin
               w_xfer = 1'b1;
               w_gnt  = w_idx;
            end
         end
      end
      if (w_xfer) begin
         w_ready[w_gnt] = 1'b1;
      end
   end

   assign in_ready = w_ready;

   // -------------------------------------------------------------------------
   // Shared detection engine, evaluated on the granted channel's context.
   // -------------------------------------------------------------------------
   always_comb begin
      w_cur   = r_ctx[w_gnt];
      w_x     = in_bit[w_gnt];
      w_nxt   = GN;
      w_match = 1'b0;
      case (w_cur)
         GN:      w_nxt = w_x ? GOT1 : GN;
         GOT1:    w_nxt = w_x ? GOT11 : GN;
         GOT11: begin
            if (w_x) begin
               w_match = 1'b1;
`ifdef SEQ_DET_RR_CTRL_OVERLAP_EN
               w_nxt   = GOT11;
`else
               // The matching 1 is reused as the first 1 of the next run.
               w_nxt   = GOT1;
`endif
            end else begin
               w_nxt = GN;
            end
         end
         // Encoding 11 is illegal and behaves exactly like GN.
         default: w_nxt = w_x ? GOT1 : GN;
      endcase
   end

   // A clear on the granted channel swallows the bit and its match.
   assign w_take_match = w_xfer & w_match & ~clr_ch[w_gnt];

   // -------------------------------------------------------------------------
   // Context / counter write-back, arbiter pointer, match report register.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            r_ctx[i] <= GN;
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (clr_ch[i]) begin
               r_ctx[i] <= GN;
               r_cnt[i] <= '0;
            end else if (w_xfer && (w_gnt == CH_W'(i))) begin
               r_ctx[i] <= w_nxt;
               if (w_match) begin
                  r_cnt[i] <= f_sat_inc(r_cnt[i]);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr      <= '0;
         r_match_valid <= 1'b0;
         r_match_ch    <= '0;
      end else begin
         if (w_xfer) begin
            r_rr_ptr <= w_gnt + CH_W'(1);
         end
         r_match_valid <= w_take_match;
         if (w_take_match) begin
            r_match_ch <= w_gnt;
         end
      end
   end

   assign match_valid = r_match_valid;
   assign match_ch    = r_match_ch;

   always_comb begin
      match_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         match_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
      end
   end

endmodule

// File: tb/tb_seq_det_rr_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for seq_det_rr_ctrl (NCH=4, CH_W=2, CNT_W=2).
// -----------------------------------------------------------------------------
module tb_seq_det_rr_ctrl;

   localparam int NCH   = 4;
   localparam int CH_W  = 2;
   localparam int CNT_W = 2;
`ifdef SEQ_DET_RR_CTRL_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_bit;
   logic [NCH-1:0]       in_ready;
   logic [NCH-1:0]       clr_ch;
   logic                 match_valid;
   logic [CH_W-1:0]      match_ch;
   logic [NCH*CNT_W-1:0] match_cnt;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   seq_det_rr_ctrl #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .in_ready    (in_ready),
      .clr_ch      (clr_ch),
      .match_valid (match_valid),
      .match_ch    (match_ch),
      .match_cnt   (match_cnt)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut;
      en       = 1'b1;
      in_valid = '0;
      in_bit   = '0;
      clr_ch   = '0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      reset_dut();
      rst = 1'b1;
      #1;
      vec++; if (match_valid !== 1'b0) begin errs++; $display("FAIL rst_mv: got %0b want 0", match_valid); end
      vec++; if (match_ch !== 2'd0) begin errs++; $display("FAIL rst_mch: got %0d want 0", match_ch); end
      vec++; if (match_cnt !== 8'h00) begin errs++; $display("FAIL rst_cnt: got %0h want 00", match_cnt); end
      rst = 1'b0;
      #1;
      vec++; if (in_ready !== 4'b0000) begin errs++; $display("FAIL rst_ready_idle: got %b want 0000", in_ready); end
      in_valid = 4'b1010;
      #1;
      vec++; if (in_ready !== 4'b0010) begin errs++; $display("FAIL rst_ready_ptr0: got %b want 0010", in_ready); end
      in_valid = '0;
   endtask

   task automatic test_single;
      logic [5:0] bits;
      logic [5:0] expm;
      int         cnt;
      bits = 6'b011110;           // bit0 first: 0,1,1,1,1,0
      expm = 6'b001000;
      expm[4] = OVL;
      cnt  = 0;
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         in_valid = 4'b0001;
         in_bit   = {3'b000, bits[i]};
         #1;
         vec++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL single_ready[%0d]: got %b want 0001", i, in_ready); end
         tick();
         if (expm[i]) cnt++;
         vec++; if (match_valid !== expm[i]) begin errs++; $display("FAIL single_mv[%0d]: got %0b want %0b", i, match_valid, expm[i]); end
         if (expm[i]) begin
            vec++; if (match_ch !== 2'd0) begin errs++; $display("FAIL single_mch[%0d]: got %0d want 0", i, match_ch); end
            vec++; if (match_cnt[1:0] !== 2'(cnt)) begin errs++; $display("FAIL single_cnt[%0d]: got %0d want %0d", i, match_cnt[1:0], cnt); end
         end
      end
      in_valid = '0;
      tick();
      vec++; if (match_valid !== 1'b0) begin errs++; $display("FAIL single_mv_end: got %0b want 0", match_valid); end
      vec++; if (match_cnt !== {6'b0, 2'(1 + int'(OVL))}) begin errs++; $display("FAIL single_cnt_end: got %0h want %0h", match_cnt, 1 + int'(OVL)); end
   endtask

   task automatic test_fairness;
      logic [3:0] exp_r;
      reset_dut();
      for (int k = 0; k < 12; k++) begin
         in_valid = 4'hF;
         in_bit   = 4'hF;
         exp_r    = 4'(1 << (k % 4));
         #1;
         vec++; if (in_ready !== exp_r) begin errs++; $display("FAIL fair_ready[%0d]: got %b want %b", k, in_ready, exp_r); end
         tick();
         vec++; if (match_valid !== (k >= 8)) begin errs++; $display("FAIL fair_mv[%0d]: got %0b want %0b", k, match_valid, (k >= 8)); end
         if (k >= 8) begin
            vec++; if (match_ch !== 2'(k - 8)) begin errs++; $display("FAIL fair_mch[%0d]: got %0d want %0d", k, match_ch, k - 8); end
         end
      end
      in_valid = '0;
      tick();
      vec++; if (match_cnt !== 8'h55) begin errs++; $display("FAIL fair_cnt: got %0h want 55", match_cnt); end
      vec++; if (match_valid !== 1'b0) begin errs++; $display("FAIL fair_mv_end: got %0b want 0", match_valid); end
   endtask

   task automatic test_isolation;
      // {in_valid, in_bit, expected ready, expected match}
      logic [3:0] v [8];
      logic [3:0] b [8];
      logic [3:0] r [8];
      logic       m [8];
      v = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0100, 4'b0100};
      b = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0100};
      r = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0100, 4'b0100};
      m = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0};
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         in_valid = v[i];
         in_bit   = b[i];
         #1;
         vec++; if (in_ready !== r[i]) begin errs++; $display("FAIL iso_ready[%0d]: got %b want %b", i, in_ready, r[i]); end
         tick();
         vec++; if (match_valid !== m[i]) begin errs++; $display("FAIL iso_mv[%0d]: got %0b want %0b", i, match_valid, m[i]); end
         if (m[i]) begin
            vec++; if (match_ch !== 2'd1) begin errs++; $display("FAIL iso_mch[%0d]: got %0d want 1", i, match_ch); end
         end
      end
      // ch2 was in GN: a third 1 is needed to match
      in_valid = 4'b0100;
      in_bit   = 4'b0100;
      tick();
      vec++; if (match_valid !== 1'b1 || match_ch !== 2'd2) begin errs++; $display("FAIL iso_ch2_match: got mv=%0b ch=%0d want mv=1 ch=2", match_valid, match_ch); end
      in_valid = '0;
      vec++; if (match_cnt !== 8'h14) begin errs++; $display("FAIL iso_cnt: got %0h want 14", match_cnt); end
   endtask

   task automatic test_clear;
      reset_dut();
      in_valid = 4'b0001;
      in_bit   = 4'b0001;
      tick();
      tick();                     // ch0 now GOT11
      clr_ch = 4'b0001;
      #1;
      vec++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL clr_ready: got %b want 0001", in_ready); end
      tick();
      clr_ch = '0;
      vec++; if (match_valid !== 1'b0) begin errs++; $display("FAIL clr_mv: got %0b want 0", match_valid); end
      vec++; if (match_cnt !== 8'h00) begin errs++; $display("FAIL clr_cnt: got %0h want 00", match_cnt); end
      // context must be GN: two 1s give no match, the third does
      for (int i = 0; i < 3; i++) begin
         tick();
         vec++; if (match_valid !== (i == 2)) begin errs++; $display("FAIL clr_ctx[%0d]: got %0b want %0b", i, match_valid, (i == 2)); end
      end
      in_valid = '0;
      vec++; if (match_cnt !== 8'h01) begin errs++; $display("FAIL clr_cnt_after: got %0h want 01", match_cnt); end
      clr_ch = 4'b0001;
      tick();
      clr_ch = '0;
      vec++; if (match_cnt !== 8'h00) begin errs++; $display("FAIL clr_idle: got %0h want 00", match_cnt); end
   endtask

   task automatic test_saturation;
      int pulses;
      int cnt;
      pulses = 0;
      cnt    = 0;
      reset_dut();
      for (int g = 0; g < 5; g++) begin
         for (int j = 0; j < 4; j++) begin
            in_valid = 4'b1000;
            in_bit   = (j < 3) ? 4'b1000 : 4'b0000;
            tick();
            if (match_valid) pulses++;
            if (j == 2) begin
               cnt = (cnt < 3) ? cnt + 1 : 3;
               vec++; if (match_valid !== 1'b1 || match_ch !== 2'd3) begin errs++; $display("FAIL sat_mv[%0d]: got mv=%0b ch=%0d want mv=1 ch=3", g, match_valid, match_ch); end
               vec++; if (match_cnt[7:6] !== 2'(cnt)) begin errs++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", g, match_cnt[7:6], cnt); end
            end
         end
      end
      in_valid = '0;
      vec++; if (pulses !== 5) begin errs++; $display("FAIL sat_pulses: got %0d want 5", pulses); end
      vec++; if (match_cnt !== 8'hC0) begin errs++; $display("FAIL sat_final: got %0h want c0", match_cnt); end
   endtask

   task automatic test_enable;
      reset_dut();
      in_valid = 4'b0001;
      in_bit   = 4'b0001;
      tick();
      tick();                     // ch0 GOT11, rr_ptr = 1
      en       = 1'b0;
      in_valid = 4'hF;
      in_bit   = 4'hF;
      for (int i = 0; i < 3; i++) begin
         #1;
         vec++; if (in_ready !== 4'b0000) begin errs++; $display("FAIL en0_ready[%0d]: got %b want 0000", i, in_ready); end
         tick();
         vec++; if (match_valid !== 1'b0) begin errs++; $display("FAIL en0_mv[%0d]: got %0b want 0", i, match_valid); end
      end
      vec++; if (match_cnt !== 8'h00) begin errs++; $display("FAIL en0_cnt: got %0h want 00", match_cnt); end
      en = 1'b1;
      #1;
      vec++; if (in_ready !== 4'b0010) begin errs++; $display("FAIL en1_ptr: got %b want 0010", in_ready); end
      tick();
      vec++; if (match_valid !== 1'b0) begin errs++; $display("FAIL en1_ch1: got %0b want 0", match_valid); end
      in_valid = 4'b0001;
      in_bit   = 4'b0001;
      #1;
      vec++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL en1_ready0: got %b want 0001", in_ready); end
      tick();
      in_valid = '0;
      vec++; if (match_valid !== 1'b1 || match_ch !== 2'd0) begin errs++; $display("FAIL en1_ctx_held: got mv=%0b ch=%0d want mv=1 ch=0", match_valid, match_ch); end
   endtask

   task automatic test_reset_mid;
      reset_dut();
      in_valid = 4'b0001;
      in_bit   = 4'b0001;
      tick();
      tick();
      tick();                     // third 1 on ch0, pulse now high
      in_valid = '0;
      vec++; if (match_valid !== 1'b1) begin errs++; $display("FAIL mid_pre: got %0b want 1", match_valid); end
      rst = 1'b1;
      #1;
      vec++; if (match_valid !== 1'b0) begin errs++; $display("FAIL mid_abort: got %0b want 0", match_valid); end
      vec++; if (match_cnt !== 8'h00) begin errs++; $display("FAIL mid_cnt: got %0h want 00", match_cnt); end
      #2;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         vec++; if (match_valid !== 1'b0) begin errs++; $display("FAIL mid_glitch[%0d]: got %0b want 0", i, match_valid); end
      end
      in_valid = 4'hF;
      in_bit   = 4'h0;
      #1;
      vec++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL mid_ptr: got %b want 0001", in_ready); end
      in_valid = '0;
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      in_valid = '0;
      in_bit   = '0;
      clr_ch   = '0;
      test_reset();
      test_single();
      test_fairness();
      test_isolation();
      test_clear();
      test_saturation();
      test_enable();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
